elevator_plant_sim: RTL

- Behavioural plant model of a 4-floor elevator car: the opposite end of the controller's motor/door/sensor interface.
- Consumes the controller's motor-up, motor-down and door commands; produces the four one-hot floor sensor lines the controller reads, plus a floor display and fault flags.
- Sits beside the elevator controller in the board top or bench, replacing the physical switches sen1..sen4 with closed-loop behaviour.

---
 rtl/elevator_plant_sim.sv | 109 ++++++++++
 1 files changed

// File: rtl/elevator_plant_sim.sv
`default_nettype none
// ============================================================================
// Module   : elevator_plant_sim
// Purpose  : Closed-loop 4-floor elevator car model driving floor sensors,
//            a 7-seg floor display and fault flags from motor/door commands.
//            Optional macro PLANT_FAULT_LATCH_EN makes fault bits sticky.
// Revision : 1.0 - initial release
// ============================================================================
module elevator_plant_sim #(
    parameter int TICKS_PER_STEP  = 4,
    parameter int STEPS_PER_FLOOR = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       motor1,
    input  logic       motor2,
    input  logic       porta,
    output logic       sen1,
    output logic       sen2,
    output logic       sen3,
    output logic       sen4,
    output logic [6:0] hex,
    output logic       moving,
    output logic [2:0] fault
);

    localparam int PMAX = 3 * STEPS_PER_FLOOR;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int CW   = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;

    localparam logic [PW-1:0] POS_MAX  = PW'(PMAX);
    localparam logic [PW-1:0] POS_F2   = PW'(STEPS_PER_FLOOR);
    localparam logic [PW-1:0] POS_F3   = PW'(2 * STEPS_PER_FLOOR);
    localparam logic [CW-1:0] PRE_LAST = CW'(TICKS_PER_STEP - 1);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_t;

    logic [PW-1:0] pos;
    logic [CW-1:0] prescaler;
    dir_t          last_dir;

    dir_t          dir;
    logic          at_top;
    logic          at_bottom;
    logic          cmd_ok;
    logic [CW-1:0] pre_base;
    logic [2:0]    fault_now;

    always_comb begin
        at_top    = (pos == POS_MAX);
        at_bottom = (pos == '0);
        dir       = DIR_NONE;
        if (motor1 && !motor2) dir = DIR_UP;
        if (motor2 && !motor1) dir = DIR_DOWN;
        cmd_ok = (dir != DIR_NONE) && !porta
                 && !(motor1 && at_top) && !(motor2 && at_bottom);
        // A reversal restarts the step timer rather than reusing partial credit.
        pre_base     = (dir == last_dir) ? prescaler : '0;
        fault_now[0] = motor1 & motor2;
        fault_now[1] = (motor1 | motor2) & porta;
        fault_now[2] = (motor1 & at_top) | (motor2 & at_bottom);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pos       <= '0;
            prescaler <= '0;
            last_dir  <= DIR_NONE;
            moving    <= 1'b0;
            fault     <= 3'b000;
        end else begin
            moving   <= cmd_ok;
            last_dir <= cmd_ok ? dir : DIR_NONE;
            if (cmd_ok) begin
                if (pre_base == PRE_LAST) begin
                    prescaler <= '0;
                    pos       <= (dir == DIR_UP) ? pos + 1'b1 : pos - 1'b1;
                end else begin
                    prescaler <= pre_base + 1'b1;
                end
            end else begin
                prescaler <= '0;
            end
`ifdef PLANT_FAULT_LATCH_EN
            fault <= fault | fault_now;
`else
            fault <= fault_now;
`endif
        end
    end

    always_comb begin
        sen1 = (pos == '0);
        sen2 = (pos == POS_F2);
        sen3 = (pos == POS_F3);
        sen4 = (pos == POS_MAX);
        hex  = 7'b0111111;
        if (sen1) hex = 7'b1111001;
        if (sen2) hex = 7'b0100100;
        if (sen3) hex = 7'b0110000;
        if (sen4) hex = 7'b0011001;
    end

endmodule
`default_nettype wire
